cbs_fmap_writer: RTL and testbench
==================================

# cbs_fmap_writer

Write-back controller for the first convolution stage. It accepts the three 160-bit CBS output channels through a valid/ready handshake and writes one word per channel per beat into three feature-map page memories. Addresses are generated in raster order (row, then word-in-row), mirroring the read-side address generation. It is the writer counterpart that stores stage outputs for the next stage to read.

## Interface
- ROWS, 40: output rows per frame
- WORDS_PER_ROW, 32: 160-bit words per row
- ADDR_W, 13: memory address width; ROWS*WORDS_PER_ROW (×2 with double buffering) must fit

- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  CBS data valid
- in_ready  out  1  writer accepts the beat when in_valid && in_ready
- data_in1, data_in2, data_in3  in  160 each  CBS channel words
- mem_ready  in  1  memories accept a write this cycle
- wr_en  out  1  write strobe, common to all three pages
- wr_addr  out  ADDR_W  write address, common to all three pages
- wr_data1, wr_data2, wr_data3  out  160 each  write data per page
- row_cnt  out  6  current input row
- col_cnt  out  8  current word in row
- bank  out  1  buffer bank being written
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last write completes

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start. Clears row_cnt, col_cnt and the linear address to base.
  - RUN→FLUSH when the last beat (row ROWS-1, col WORDS_PER_ROW-1) is accepted.
  - FLUSH→DONE when the hold register is drained.
  - DONE→IDLE unconditionally after one cycle.
- A start pulse outside IDLE is ignored.
- Hold register: one entry holding three data words and an address.
  - An accepted beat loads it. hold_valid drives wr_en.
  - Entry retires on wr_en && mem_ready.
- in_ready = (state==RUN) && (!hold_valid || mem_ready). Retire and load in the same cycle are allowed, giving full throughput.
- Counters advance on each accepted beat:
  - col_cnt wraps WORDS_PER_ROW-1→0 and increments row_cnt.
  - The linear address increments by 1.
  - The address equals base + row_cnt*WORDS_PER_ROW + col_cnt. Implement it as an incrementer, not a multiplier.
- Data passes bit-exact: no lane reordering or arithmetic.
- busy=1 in RUN, FLUSH and DONE.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data*=0, row_cnt=0, col_cnt=0, bank=0, busy=0, frame_done=0, state IDLE, hold empty.
- Reset mid-frame discards the hold entry; no further write is issued.

## Timing
- Latency: a beat accepted at edge N appears on wr_en/wr_addr/wr_data at cycle N+1.
- Output stays stable while wr_en && !mem_ready.
- frame_done asserts the cycle after the final write retires, in state DONE.
- in_ready is 0 in the cycle start is sampled. It rises the cycle after (RUN).
- mem_ready low stalls indefinitely with no data loss or duplication.
- With in_valid held high and mem_ready=1, a frame takes ROWS*WORDS_PER_ROW + 3 cycles from start to frame_done.

## Configuration
- FMAP_DOUBLE_BUF_EN defined:
  - Ping-pong buffering. base = bank ? ROWS*WORDS_PER_ROW : 0.
  - bank toggles on the DONE→IDLE transition, so the reader consumes the other bank.
- FMAP_DOUBLE_BUF_EN undefined: bank is tied to 0 and base is always 0.

## Test plan
- Full-rate frame:
  - Stimulus: ROWS=4, WORDS_PER_ROW=4, in_valid=1, mem_ready=1, data_in1=beat index.
  - Response: 16 writes at addresses 0..15, data 0..15. frame_done at cycle 19 after start.
- Row wrap:
  - Stimulus: accept the beat at col 3, row 0.
  - Response: next state is col_cnt=0, row_cnt=1, next wr_addr=4.
- Backpressure:
  - Stimulus: mem_ready=0 for 5 cycles after the 3rd write.
  - Response: wr_addr=2 held with wr_en=1; in_ready=0. Sequence resumes at address 3 with no gaps or duplicates.
- Ignored start and bubbles:
  - Stimulus: start pulsed mid-frame; in_valid toggled 1/0.
  - Response: counters unaffected; 16 writes total.
- Reset mid-frame:
  - Stimulus: reset at beat 7.
  - Response: next cycle all outputs are at reset values. Next frame starts at address 0.
- Double buffering (FMAP_DOUBLE_BUF_EN):
  - Stimulus: two back-to-back frames.
  - Response: frame 1 writes addresses 0..15 with bank=0; frame 2 writes 16..31 with bank=1. Without the macro, both frames write 0..15.

Source files
------------

// File: rtl/cbs_fmap_writer_if.sv
// CBS stream input plus feature-map page write port, shared by the
// writer (slave) and the producer/memory side (master).
interface cbs_fmap_writer_if #(
  parameter int ADDR_W = 13
);
  logic              in_valid;
  logic              in_ready;
  logic [159:0]      data_in1;
  logic [159:0]      data_in2;
  logic [159:0]      data_in3;
  logic              mem_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [159:0]      wr_data1;
  logic [159:0]      wr_data2;
  logic [159:0]      wr_data3;

  modport slave (
    input  in_valid, data_in1, data_in2, data_in3, mem_ready,
    output in_ready, wr_en, wr_addr, wr_data1, wr_data2, wr_data3
  );

  modport master (
    output in_valid, data_in1, data_in2, data_in3, mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data1, wr_data2, wr_data3
  );
endinterface

// File: rtl/cbs_fmap_writer.sv
// Feature-map write-back controller: takes three 160-bit CBS channel
// words per beat and writes them in raster order to three page memories.
// Ports: clk, reset (sync, active-high), start; bus (slave modport:
// in_valid/in_ready/data_in1..3, mem_ready/wr_en/wr_addr/wr_data1..3);
// row_cnt, col_cnt, bank, busy, frame_done.
// Option: FMAP_DOUBLE_BUF_EN enables ping-pong banks (base toggles).
module cbs_fmap_writer #(
  parameter int ROWS          = 40,
  parameter int WORDS_PER_ROW = 32,
  parameter int ADDR_W        = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  cbs_fmap_writer_if.slave         bus,
  output logic [5:0]               row_cnt,
  output logic [7:0]               col_cnt,
  output logic                     bank,
  output logic                     busy,
  output logic                     frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic [7:0] COL_LAST = 8'(WORDS_PER_ROW - 1);

  state_t            state_q;
  state_t            state_d;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [159:0]      hold_d1;
  logic [159:0]      hold_d2;
  logic [159:0]      hold_d3;
  logic [ADDR_W-1:0] lin_addr;
  logic [ADDR_W-1:0] base;
  logic              bank_q;
  logic              accept;
  logic              retire;
  logic              last_beat;

`ifdef FMAP_DOUBLE_BUF_EN
  localparam int FRAME_WORDS = ROWS * WORDS_PER_ROW;

  // Flip after each frame so the reader consumes the finished bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= 1'b0;
    end else if (state_q == DONE) begin
      bank_q <= ~bank_q;
    end
  end

  assign base = bank_q ? ADDR_W'(FRAME_WORDS) : '0;
`else
  assign bank_q = 1'b0;
  assign base   = '0;
`endif

  assign bank = bank_q;

  // Hold may retire and reload in one cycle: full throughput.
  assign retire    = hold_valid && bus.mem_ready;
  assign bus.in_ready = (state_q == RUN)
                     && (!hold_valid || bus.mem_ready);
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = (row_cnt == ROW_LAST)
                  && (col_cnt == COL_LAST);

  assign bus.wr_en    = hold_valid;
  assign bus.wr_addr  = hold_addr;
  assign bus.wr_data1 = hold_d1;
  assign bus.wr_data2 = hold_d2;
  assign bus.wr_data3 = hold_d3;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_beat) state_d = FLUSH;
      FLUSH:   if (!hold_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster counters; the address is a running incrementer from base.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt  <= '0;
      col_cnt  <= '0;
      lin_addr <= '0;
    end else if (state_q == IDLE && start) begin
      row_cnt  <= '0;
      col_cnt  <= '0;
      lin_addr <= base;
    end else if (accept) begin
      lin_addr <= lin_addr + ADDR_W'(1);
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        if (row_cnt == ROW_LAST) begin
          row_cnt <= '0;
        end else begin
          row_cnt <= row_cnt + 6'd1;
        end
      end else begin
        col_cnt <= col_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_d1    <= '0;
      hold_d2    <= '0;
      hold_d3    <= '0;
    end else begin
      if (retire) begin
        hold_valid <= 1'b0;
      end
      if (accept) begin
        hold_valid <= 1'b1;
        hold_addr  <= lin_addr;
        hold_d1    <= bus.data_in1;
        hold_d2    <= bus.data_in2;
        hold_d3    <= bus.data_in3;
      end
    end
  end

endmodule

// File: tb/tb_cbs_fmap_writer.sv
// Self-checking bench for cbs_fmap_writer (4x4 frame): cycle table,
// backpressure, bubbles, reset mid-frame and a write scoreboard.
module tb_cbs_fmap_writer;

  localparam int ROWS = 4;
  localparam int WPR  = 4;
  localparam int AW   = 13;
  localparam int NB   = ROWS * WPR;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] row_cnt;
  logic [7:0] col_cnt;
  logic       bank;
  logic       busy;
  logic       frame_done;

  cbs_fmap_writer_if #(.ADDR_W(AW)) bus ();

  cbs_fmap_writer #(
    .ROWS(ROWS),
    .WORDS_PER_ROW(WPR),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .row_cnt(row_cnt),
    .col_cnt(col_cnt),
    .bank(bank),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [159:0]  d1;
    logic [159:0]  d2;
    logic [159:0]  d3;
  } wr_t;

  typedef struct {
    logic          ir;
    logic          we;
    logic [AW-1:0] addr;
    logic [159:0]  d1;
    logic [159:0]  d2;
    logic [159:0]  d3;
    logic [5:0]    row;
    logic [7:0]    col;
    logic          bank;
    logic          busy;
    logic          fd;
  } snap_t;

  typedef struct {
    int   cyc;
    logic ir;
    logic we;
    int   addr;
    bit   chk_rc;
    int   row;
    int   col;
    logic busy;
    logic fd;
  } vec_t;

  wr_t   exp_q[$];
  wr_t   ew;
  snap_t s;
  vec_t  tbl[11];
  int    mdl_base;
  int    mdl_beat;
  int    wr_cnt;
  int    sent;
  int    frames;
  bit    acc;

  task automatic check(input string nm,
                       input logic [159:0] act,
                       input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_bank();
`ifdef FMAP_DOUBLE_BUF_EN
    return frames % 2;
`else
    return 0;
`endif
  endfunction

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom()};
  endfunction

  // Scoreboard: every accepted beat must be written once, in order,
  // at base + beat index, with bit-exact data.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en && bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 160'(exp_q.size()), 160'(1));
        end else begin
          ew = exp_q.pop_front();
          check("wr_addr", 160'(bus.wr_addr), 160'(ew.addr));
          check("wr_data1", bus.wr_data1, ew.d1);
          check("wr_data2", bus.wr_data2, ew.d2);
          check("wr_data3", bus.wr_data3, ew.d3);
        end
        wr_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{AW'(mdl_base + mdl_beat),
                         bus.data_in1, bus.data_in2,
                         bus.data_in3});
        mdl_beat++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    s.ir   = bus.in_ready;
    s.we   = bus.wr_en;
    s.addr = bus.wr_addr;
    s.d1   = bus.wr_data1;
    s.d2   = bus.wr_data2;
    s.d3   = bus.wr_data3;
    s.row  = row_cnt;
    s.col  = col_cnt;
    s.bank = bank;
    s.busy = busy;
    s.fd   = frame_done;
    acc    = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (acc) sent++;
  endtask

  // mode 0 full rate, 1 backpressure, 2 random, 3 bubbles+start,
  // 4 reset mid-frame
  task automatic drive(input int mode, input int c);
    start = (c == 0) || (mode == 3 && c == 6);
    if (sent >= NB) begin
      bus.in_valid = 1'b0;
    end else if (mode == 2) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
    end else if (mode == 3) begin
      bus.in_valid = (c % 2 == 1);
    end else begin
      bus.in_valid = 1'b1;
    end
    if (mode == 1) begin
      bus.mem_ready = !(c >= 4 && c <= 8);
    end else if (mode == 2) begin
      bus.mem_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.mem_ready = 1'b1;
    end
    bus.data_in1 = (mode == 0) ? 160'(sent) : rnd160();
    bus.data_in2 = rnd160();
    bus.data_in3 = rnd160();
  endtask

  task automatic frame(input int mode);
    int done_c;
    int c;
    mdl_base = exp_bank() * NB;
    mdl_beat = 0;
    wr_cnt   = 0;
    sent     = 0;
    done_c   = -1;
    for (c = 0; c < 600; c++) begin
      drive(mode, c);
      if (mode == 4 && c == 8) begin
        reset = 1'b1;
        break;
      end
      step();
      if (mode == 0) begin
        for (int i = 0; i < 11; i++) begin
          if (tbl[i].cyc == c) begin
            check("t_in_ready", 160'(s.ir), 160'(tbl[i].ir));
            check("t_wr_en", 160'(s.we), 160'(tbl[i].we));
            if (tbl[i].we)
              check("t_wr_addr", 160'(s.addr),
                    160'(mdl_base + tbl[i].addr));
            if (tbl[i].chk_rc) begin
              check("t_row", 160'(s.row), 160'(tbl[i].row));
              check("t_col", 160'(s.col), 160'(tbl[i].col));
            end
            check("t_busy", 160'(s.busy), 160'(tbl[i].busy));
            check("t_done", 160'(s.fd), 160'(tbl[i].fd));
          end
        end
      end
      if (mode == 1 && c >= 4 && c <= 8) begin
        check("bp_wr_en", 160'(s.we), 160'(1));
        check("bp_addr", 160'(s.addr), 160'(mdl_base + 2));
        check("bp_in_ready", 160'(s.ir), 160'(0));
      end
      if (c == 1)
        check("bank", 160'(s.bank), 160'(exp_bank()));
      if (s.fd) begin
        done_c = c;
        break;
      end
    end
    if (mode == 4) begin
      step();
      reset = 1'b0;
      start = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      frames = 0;
      step();
      check("rst_in_ready", 160'(s.ir), 160'(0));
      check("rst_wr_en", 160'(s.we), 160'(0));
      check("rst_wr_addr", 160'(s.addr), 160'(0));
      check("rst_wr_data1", s.d1, 160'(0));
      check("rst_row", 160'(s.row), 160'(0));
      check("rst_col", 160'(s.col), 160'(0));
      check("rst_bank", 160'(s.bank), 160'(0));
      check("rst_busy", 160'(s.busy), 160'(0));
    end else begin
      check("frame_done_seen", 160'(done_c >= 0), 160'(1));
      if (mode == 0)
        check("latency_full", 160'(done_c), 160'(NB + 3));
      if (mode == 1)
        check("latency_bp", 160'(done_c), 160'(NB + 8));
      start = 1'b0;
      bus.in_valid = 1'b0;
      step();
      check("done_pulse", 160'(s.fd), 160'(0));
      check("idle_busy", 160'(s.busy), 160'(0));
      check("wr_count", 160'(wr_cnt), 160'(NB));
      check("q_empty", 160'(exp_q.size()), 160'(0));
      frames++;
    end
  endtask

  initial begin
    // cyc, in_ready, wr_en, addr, chk_rc, row, col, busy, done
    tbl[0]  = '{0,  1'b0, 1'b0, 0,  1'b1, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b0, 0,  1'b1, 0, 0, 1'b1, 1'b0};
    tbl[2]  = '{2,  1'b1, 1'b1, 0,  1'b1, 0, 1, 1'b1, 1'b0};
    tbl[3]  = '{4,  1'b1, 1'b1, 2,  1'b1, 0, 3, 1'b1, 1'b0};
    tbl[4]  = '{5,  1'b1, 1'b1, 3,  1'b1, 1, 0, 1'b1, 1'b0};
    tbl[5]  = '{6,  1'b1, 1'b1, 4,  1'b1, 1, 1, 1'b1, 1'b0};
    tbl[6]  = '{12, 1'b1, 1'b1, 10, 1'b1, 2, 3, 1'b1, 1'b0};
    tbl[7]  = '{16, 1'b1, 1'b1, 14, 1'b1, 3, 3, 1'b1, 1'b0};
    tbl[8]  = '{17, 1'b0, 1'b1, 15, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[9]  = '{18, 1'b0, 1'b0, 0,  1'b0, 0, 0, 1'b1, 1'b0};
    tbl[10] = '{19, 1'b0, 1'b0, 0,  1'b0, 0, 0, 1'b1, 1'b1};

    reset         = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    bus.data_in1  = '0;
    bus.data_in2  = '0;
    bus.data_in3  = '0;
    mdl_base      = 0;
    mdl_beat      = 0;
    wr_cnt        = 0;
    sent          = 0;
    frames        = 0;
    step();
    step();
    step();
    check("r_in_ready", 160'(s.ir), 160'(0));
    check("r_wr_en", 160'(s.we), 160'(0));
    check("r_wr_addr", 160'(s.addr), 160'(0));
    check("r_wr_data1", s.d1, 160'(0));
    check("r_wr_data2", s.d2, 160'(0));
    check("r_wr_data3", s.d3, 160'(0));
    check("r_row", 160'(s.row), 160'(0));
    check("r_col", 160'(s.col), 160'(0));
    check("r_bank", 160'(s.bank), 160'(0));
    check("r_busy", 160'(s.busy), 160'(0));
    check("r_done", 160'(s.fd), 160'(0));
    reset = 1'b0;
    step();

    frame(0);
    frame(1);
    frame(2);
    frame(2);
    frame(2);
    frame(3);
    frame(4);
    frame(2);
    frame(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
